mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequential data-memory access controller between the datapath control unit and the 64-bit data memory. Accepts one load/store request at a time, sequences the memory read, the read-modify-write for sub-word stores, and the result return. Loads are sign- or zero-extended and returned toward the register bank; stores are merged into the memory word before it is written back.

## Interface
Parameters:
- MEM_LAT, 1: cycles from `mem_rd` assertion to valid `mem_rdata`, range 1–4.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  access type: 0000 lb, 0001 lh, 0010 lw, 0011 lbu, 0100 lhu, 0101 lwu, 0110 sd, 0111 sw, 1000 sh, 1001 sb, 1010 ld; others reserved.
- req_addr  in  64  byte address.
- req_wdata  in  64  store source (rs2).
- mem_addr  out  64  word address `{req_addr[63:3],3'b000}`.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  64  merged write word.
- mem_rdata  in  64  read word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  64  extended load result; 0 for stores and errors.
- resp_err  out  1  qualifies `resp_valid`: reserved op or trapped misalignment.

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op, addr, and wdata.
  - ld / loads / sw / sh / sb → RD.
  - sd → WR.
  - reserved op → RESP with `resp_err`=1.
- RD: `mem_rd`=1 for exactly one cycle → WAIT.
- WAIT: count MEM_LAT cycles. On the last cycle, capture `mem_rdata`. Loads → RESP; sub-word stores → WR.
- WR: `mem_wr`=1 for one cycle → RESP.
  - sd: write the full latched wdata.
  - sw/sh/sb: replace only the selected lane of the captured word with the low bits of wdata; keep other bytes.
- RESP: `resp_valid`=1 for one cycle → IDLE.
- Lane selection uses offset `off = req_addr[2:0]`:
  - byte at bits [8·off+7 : 8·off];
  - halfword at offset off (off even);
  - word at off 0 or 4.
- Extension:
  - lb/lh/lw replicate the lane MSB to fill 64 bits.
  - lbu/lhu/lwu zero-fill.
  - ld returns the full word.
  - Widths are exact: 56/48/32 fill bits.
- `resp_data` is registered. It holds its value until the next RESP and is 0 for stores and errors.
- `req_valid` outside IDLE is ignored, with no queuing.

## Timing
- Accept at edge T (cycle 0). Then:
  - Loads: `mem_rd` in cycle 1, capture in cycle 1+MEM_LAT, `resp_valid` in cycle 2+MEM_LAT.
  - sw/sh/sb: `mem_wr` in cycle 2+MEM_LAT, `resp_valid` in cycle 3+MEM_LAT.
  - sd: `mem_wr` in cycle 1, `resp_valid` in cycle 2.
  - Reserved op: `resp_valid` in cycle 1.
- Back-to-back operation: a new request can be accepted in the cycle after `resp_valid`.
- `mem_addr` is stable from RD through WR.
- Reset values (immediate, asynchronous):
  - state=IDLE.
  - `req_ready`=1.
  - `mem_rd`=`mem_wr`=`resp_valid`=`resp_err`=0.
  - `resp_data`=0, `mem_wdata`=0, `mem_addr`=0.
  - WAIT counter=0.
- Reset mid-operation aborts the access. No strobe is issued after reset asserts. A write already sampled by memory is not undone.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - a halfword with odd off, or a word with off∉{0,4}, goes IDLE→RESP with `resp_err`=1;
  - no `mem_rd`/`mem_wr`;
  - same latency as a reserved op.
- Undefined: offsets are truncated to natural alignment (`off & ~(size-1)`) and the access proceeds normally. `resp_err` is set only for reserved ops.

## Structure
- Package `lsu_pkg`:
  - `lsu_op_t` enum holding the 4-bit encodings above;
  - `lsu_state_t` enum;
  - lane-size helper constants.
- Sub-module `lsu_lane`: combinational lane extract/extend for loads and lane merge for stores, driven by op and off. The FSM, counter, and registers stay in `mem_access_ctrl`.

## Test plan
- lb, addr 0x...0003, rdata 0x0000_0000_80FF_0000 → `resp_data`=0xFFFF_FFFF_FFFF_FF80 at cycle 2+MEM_LAT.
- lhu, addr offset 6, rdata 0xBEEF_0000_0000_0000 → `resp_data`=0x0000_0000_0000_BEEF; same with lh → 0xFFFF_FFFF_FFFF_BEEF.
- sb, off 1, wdata 0xAB, rdata 0x1122_3344_5566_7788 → `mem_wdata`=0x1122_3344_5566_AB88 with `mem_wr` at cycle 2+MEM_LAT; `resp_valid` one cycle later.
- sd, wdata 0xDEAD_BEEF_CAFE_F00D → `mem_wr` at cycle 1, no `mem_rd`; `resp_valid` at cycle 2.
- Reserved op 1011, and (with MISALIGN_TRAP_EN) lw at off 2 → `resp_err`=1 at cycle 1, no memory strobes. Without the macro, the lw reads lane 0.
- Reset asserted in WAIT with MEM_LAT=3 → all outputs at reset values immediately; no subsequent `mem_wr`; next request processed normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the data-memory access controller.
//   lsu_op_t    - 4-bit access-type encodings (values above OP_LD are reserved)
//   lsu_state_t - controller sequencing states
//   LANE_*      - lane sizes in bytes
//   op_*        - small decode helpers shared by the controller and lane logic
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'b0000,
      OP_LH  = 4'b0001,
      OP_LW  = 4'b0010,
      OP_LBU = 4'b0011,
      OP_LHU = 4'b0100,
      OP_LWU = 4'b0101,
      OP_SD  = 4'b0110,
      OP_SW  = 4'b0111,
      OP_SH  = 4'b1000,
      OP_SB  = 4'b1001,
      OP_LD  = 4'b1010
   } lsu_op_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } lsu_state_t;

   localparam logic [3:0] LANE_B = 4'd1;
   localparam logic [3:0] LANE_H = 4'd2;
   localparam logic [3:0] LANE_W = 4'd4;
   localparam logic [3:0] LANE_D = 4'd8;

   // Access size in bytes; reserved encodings report a full word.
   function automatic logic [3:0] op_size(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return LANE_B;
         OP_LH, OP_LHU, OP_SH: return LANE_H;
         OP_LW, OP_LWU, OP_SW: return LANE_W;
         OP_LD, OP_SD:         return LANE_D;
         default:              return LANE_D;
      endcase
   endfunction

   function automatic logic op_reserved(input logic [3:0] op);
      return (op > 4'b1010);
   endfunction

   function automatic logic op_is_load(input logic [3:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD: return 1'b1;
         default:                                            return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_signed(input logic [3:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   // Halfwords need an even offset, words need offset 0 or 4.
   function automatic logic op_misaligned(input logic [3:0] op, input logic [2:0] off);
      case (op_size(op))
         LANE_H:  return off[0];
         LANE_W:  return (off[1:0] != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, memory and response signals of the access controller.
//   req_*  - request handshake from the control unit (ready high only when idle)
//   mem_*  - 64-bit data-memory port (word address, read/write strobes, data)
//   resp_* - one-cycle completion pulse with extended load data and error flag
// Modports: master = requester/memory side, slave = controller.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [63:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_rdata,
      input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
             resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
      output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
             resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane handling for one access.
//   op, off    - access type and byte offset within the 64-bit word
//   rdata      - word read from memory
//   wdata      - store source; its low bytes are merged into the lane
//   load_data  - selected lane, sign- or zero-extended to 64 bits
//   store_data - rdata with the selected lane replaced by wdata
// The offset is always truncated to natural alignment; misaligned accesses that
// must trap never reach this logic.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [2:0]  off,
   input  logic [63:0] rdata,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] store_data
);

   logic [3:0]  size_s;
   logic [2:0]  off_al_s;
   logic [63:0] size_mask_s;
   logic [5:0]  shamt_s;
   logic [63:0] lane_s;
   logic        msb_s;

   assign size_s = op_size(op);

   // Aligned offset and lane mask for the access size.
   always_comb begin
      off_al_s    = 3'b000;
      size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
      case (size_s)
         LANE_B: begin
            off_al_s    = off;
            size_mask_s = 64'h0000_0000_0000_00FF;
         end
         LANE_H: begin
            off_al_s    = {off[2:1], 1'b0};
            size_mask_s = 64'h0000_0000_0000_FFFF;
         end
         LANE_W: begin
            off_al_s    = {off[2], 2'b00};
            size_mask_s = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            off_al_s    = 3'b000;
            size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
         end
      endcase
   end

   assign shamt_s = {off_al_s, 3'b000};
   assign lane_s  = (rdata >> shamt_s) & size_mask_s;

   // Sign bit of the extracted lane; a full word never needs extension.
   always_comb begin
      msb_s = 1'b0;
      case (size_s)
         LANE_B:  msb_s = lane_s[7];
         LANE_H:  msb_s = lane_s[15];
         LANE_W:  msb_s = lane_s[31];
         default: msb_s = 1'b0;
      endcase
   end

   // Fill bits above the lane with copies of its MSB for signed loads.
   always_comb begin
      load_data = lane_s;
      if (op_is_signed(op) && msb_s) begin
         load_data = lane_s | ~size_mask_s;
      end else begin
         load_data = lane_s;
      end
   end

   assign store_data = (rdata & ~(size_mask_s << shamt_s)) |
                       ((wdata & size_mask_s) << shamt_s);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential data-memory access controller.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   bus          - mem_access_ctrl_if.slave (request, memory and response signals)
// Parameter MEM_LAT (1..4): cycles from mem_rd to valid mem_rdata.
// Macro MISALIGN_TRAP_EN: when defined, misaligned halfword/word accesses are
// answered with resp_err and no memory traffic; otherwise the offset is
// truncated to natural alignment.
// All outputs are registered from the next state, so each strobe is high
// exactly while the FSM sits in the matching state.
module mem_access_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_LAT = 1
)
(
   input  logic            clock,
   input  logic            reset,
   mem_access_ctrl_if.slave bus
);

   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   lsu_state_t  state_r;
   lsu_state_t  state_next_s;
   logic [3:0]  op_r;
   logic [2:0]  off_r;
   logic [63:0] wdata_r;
   logic [2:0]  wait_cnt_r;
   logic        wait_last_s;
   logic        trap_s;
   logic        req_err_s;
   logic        accept_s;
   logic [63:0] load_data_s;
   logic [63:0] store_data_s;

   logic        req_ready_r;
   logic [63:0] mem_addr_r;
   logic        mem_rd_r;
   logic        mem_wr_r;
   logic [63:0] mem_wdata_r;
   logic        resp_valid_r;
   logic [63:0] resp_data_r;
   logic        resp_err_r;

`ifdef MISALIGN_TRAP_EN
   assign trap_s = op_misaligned(bus.req_op, bus.req_addr[2:0]);
`else
   assign trap_s = 1'b0;
`endif

   assign req_err_s   = op_reserved(bus.req_op) | trap_s;
   assign accept_s    = (state_r == ST_IDLE) && bus.req_valid;
   assign wait_last_s = (wait_cnt_r == LAT_LAST);

   lsu_lane u_lane (
      .op         (op_r),
      .off        (off_r),
      .rdata      (bus.mem_rdata),
      .wdata      (wdata_r),
      .load_data  (load_data_s),
      .store_data (store_data_s)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!bus.req_valid) begin
               state_next_s = ST_IDLE;
            end else if (req_err_s) begin
               state_next_s = ST_RESP;
            end else if (bus.req_op == OP_SD) begin
               state_next_s = ST_WR;
            end else begin
               state_next_s = ST_RD;
            end
         end
         ST_RD: begin
            state_next_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (!wait_last_s) begin
               state_next_s = ST_WAIT;
            end else if (op_is_load(op_r)) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_WR;
            end
         end
         ST_WR: begin
            state_next_s = ST_RESP;
         end
         ST_RESP: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Latch the accepted request and count read latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_r       <= 4'b0000;
         off_r      <= 3'b000;
         wdata_r    <= 64'h0;
         mem_addr_r <= 64'h0;
         wait_cnt_r <= 3'd0;
      end else begin
         if (accept_s) begin
            op_r       <= bus.req_op;
            off_r      <= bus.req_addr[2:0];
            wdata_r    <= bus.req_wdata;
            mem_addr_r <= {bus.req_addr[63:3], 3'b000};
         end
         if ((state_r == ST_WAIT) && !wait_last_s) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
         end else begin
            wait_cnt_r <= 3'd0;
         end
      end
   end

   // Strobes and ready follow the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_ready_r  <= 1'b1;
         mem_rd_r     <= 1'b0;
         mem_wr_r     <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
      end else begin
         req_ready_r  <= (state_next_s == ST_IDLE);
         mem_rd_r     <= (state_next_s == ST_RD);
         mem_wr_r     <= (state_next_s == ST_WR);
         resp_valid_r <= (state_next_s == ST_RESP);
         // RESP is only entered straight from IDLE for an error.
         resp_err_r   <= (state_next_s == ST_RESP) && (state_r == ST_IDLE);
      end
   end

   // Write word (full for sd, merged for sub-word stores) and load result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_wdata_r <= 64'h0;
         resp_data_r <= 64'h0;
      end else begin
         if (accept_s && !req_err_s && (bus.req_op == OP_SD)) begin
            mem_wdata_r <= bus.req_wdata;
         end else if ((state_r == ST_WAIT) && wait_last_s && !op_is_load(op_r)) begin
            mem_wdata_r <= store_data_s;
         end
         // Only a load reaches RESP from WAIT; stores and errors return 0.
         if (state_next_s == ST_RESP) begin
            resp_data_r <= (state_r == ST_WAIT) ? load_data_s : 64'h0;
         end
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_rd     = mem_rd_r;
   assign bus.mem_wr     = mem_wr_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_data  = resp_data_r;
   assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus randomized bench for mem_access_ctrl with
// a byte-level reference model and a memory that presents read data only in
// the cycle it is valid.
module tb_mem_access_ctrl;

   localparam int          LAT  = 3;
   localparam logic [63:0] JUNK = 64'h5A5A_C3C3_3C3C_A5A5;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_access_ctrl_if bus();

   mem_access_ctrl #(.MEM_LAT(LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Memory: read data valid exactly LAT cycles after the mem_rd cycle.
   logic [63:0] mem_word;
   logic [3:0]  rd_hist;
   always @(posedge clock or posedge reset) begin
      if (reset) rd_hist <= 4'b0000;
      else       rd_hist <= {rd_hist[2:0], bus.mem_rd};
   end
   assign bus.mem_rdata = rd_hist[LAT-1] ? mem_word : JUNK;

   int n_pass  = 0;
   int n_total = 0;
   logic [63:0] last_data;
   logic [63:0] last_wdata;
   logic        last_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // kind: 0 load, 1 sd, 2 sub-word store, 3 reserved
   task automatic op_info(input logic [3:0] op, output int size, output bit sgn, output int kind);
      sgn = 1'b0; size = 8; kind = 3;
      case (op)
         4'd0:  begin size = 1; sgn = 1'b1; kind = 0; end
         4'd1:  begin size = 2; sgn = 1'b1; kind = 0; end
         4'd2:  begin size = 4; sgn = 1'b1; kind = 0; end
         4'd3:  begin size = 1; kind = 0; end
         4'd4:  begin size = 2; kind = 0; end
         4'd5:  begin size = 4; kind = 0; end
         4'd6:  begin size = 8; kind = 1; end
         4'd7:  begin size = 4; kind = 2; end
         4'd8:  begin size = 2; kind = 2; end
         4'd9:  begin size = 1; kind = 2; end
         4'd10: begin size = 8; kind = 0; end
         default: begin size = 8; kind = 3; end
      endcase
   endtask

   function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                              input int size, input bit sgn);
      logic [63:0] r;
      int base;
      r = 64'h0;
      base = off - (off % size);
      for (int i = 0; i < size; i++) r[8*i +: 8] = word[8*(base+i) +: 8];
      if (sgn && r[8*size-1]) begin
         for (int i = size; i < 8; i++) r[8*i +: 8] = 8'hFF;
      end
      return r;
   endfunction

   function automatic logic [63:0] model_store(input logic [63:0] word, input int off,
                                               input int size, input logic [63:0] wd);
      logic [63:0] r;
      int base;
      r = word;
      base = off - (off % size);
      for (int i = 0; i < size; i++) r[8*(base+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   task automatic run_req(input string name, input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] word);
      int size, kind, off;
      bit sgn, err;
      int exp_rd_c, exp_wr_c, exp_resp_c;
      logic [63:0] exp_data, exp_wdata;
      int rd_n, wr_n, resp_n, rd_c, wr_c, resp_c, ready_bad;
      logic [63:0] wd_seen, data_seen, addr_seen;
      logic err_seen;

      op_info(op, size, sgn, kind);
      off = int'(addr[2:0]);
      err = (kind == 3) || (TRAP && (size == 2 || size == 4) && (off % size != 0));
      exp_data = 64'h0; exp_wdata = 64'h0;
      exp_rd_c = 0; exp_wr_c = 0; exp_resp_c = 1;
      if (!err) begin
         case (kind)
            0: begin exp_rd_c = 1; exp_resp_c = 2 + LAT; exp_data = model_load(word, off, size, sgn); end
            1: begin exp_wr_c = 1; exp_resp_c = 2; exp_wdata = wd; end
            default: begin exp_rd_c = 1; exp_wr_c = 2 + LAT; exp_resp_c = 3 + LAT;
                            exp_wdata = model_store(word, off, size, wd); end
         endcase
      end

      @(negedge clock);
      mem_word = word;
      check({name, "/ready_idle"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
      @(negedge clock);
      bus.req_valid = 1'b0;

      rd_n = 0; wr_n = 0; resp_n = 0; rd_c = 0; wr_c = 0; resp_c = 0; ready_bad = 0;
      wd_seen = 64'h0; data_seen = 64'h0; addr_seen = 64'h0; err_seen = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (bus.mem_rd)  begin rd_n++; rd_c = c; end
         if (bus.mem_wr)  begin wr_n++; wr_c = c; wd_seen = bus.mem_wdata; end
         if (bus.resp_valid) begin
            resp_n++; resp_c = c; data_seen = bus.resp_data;
            err_seen = bus.resp_err; addr_seen = bus.mem_addr;
         end
         if (bus.req_ready !== (c > exp_resp_c)) ready_bad++;
         @(negedge clock);
      end

      check({name, "/rd_count"}, 64'(rd_n), 64'(exp_rd_c != 0));
      check({name, "/rd_cycle"}, 64'(rd_c), 64'(exp_rd_c));
      check({name, "/wr_count"}, 64'(wr_n), 64'(exp_wr_c != 0));
      check({name, "/wr_cycle"}, 64'(wr_c), 64'(exp_wr_c));
      if (exp_wr_c != 0) check({name, "/wdata"}, wd_seen, exp_wdata);
      check({name, "/resp_count"}, 64'(resp_n), 64'd1);
      check({name, "/resp_cycle"}, 64'(resp_c), 64'(exp_resp_c));
      check({name, "/resp_data"}, data_seen, exp_data);
      check({name, "/resp_err"}, 64'(err_seen), 64'(err));
      check({name, "/mem_addr"}, addr_seen, {addr[63:3], 3'b000});
      check({name, "/ready_seq"}, 64'(ready_bad), 64'd0);
      check({name, "/data_hold"}, bus.resp_data, exp_data);
      last_data = data_seen; last_wdata = wd_seen; last_err = err_seen;
   endtask

   initial begin
      int rd_n, wr_n, resp_n;
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_op = 4'b0000;
      bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
      mem_word = 64'h0;
      repeat (2) @(negedge clock);
      check("rst/req_ready",  64'(bus.req_ready),  64'd1);
      check("rst/mem_rd",     64'(bus.mem_rd),     64'd0);
      check("rst/mem_wr",     64'(bus.mem_wr),     64'd0);
      check("rst/resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst/resp_err",   64'(bus.resp_err),   64'd0);
      check("rst/resp_data",  bus.resp_data,       64'h0);
      check("rst/mem_wdata",  bus.mem_wdata,       64'h0);
      check("rst/mem_addr",   bus.mem_addr,        64'h0);
      reset = 1'b0;

      // Directed cases
      run_req("lb_off3", 4'b0000, 64'h0000_0000_1000_0003, 64'h0, 64'h0000_0000_80FF_0000);
      check("lb_off3/const", last_data, 64'hFFFF_FFFF_FFFF_FF80);
      run_req("lhu_off6", 4'b0100, 64'h0000_0000_2000_0006, 64'h0, 64'hBEEF_0000_0000_0000);
      check("lhu_off6/const", last_data, 64'h0000_0000_0000_BEEF);
      run_req("lh_off6", 4'b0001, 64'h0000_0000_2000_0006, 64'h0, 64'hBEEF_0000_0000_0000);
      check("lh_off6/const", last_data, 64'hFFFF_FFFF_FFFF_BEEF);
      run_req("sb_off1", 4'b1001, 64'h0000_0000_3000_0001, 64'h0000_0000_0000_00AB,
              64'h1122_3344_5566_7788);
      check("sb_off1/const", last_wdata, 64'h1122_3344_5566_AB88);
      run_req("sd", 4'b0110, 64'h0000_0000_4000_0008, 64'hDEAD_BEEF_CAFE_F00D, 64'h0);
      check("sd/const", last_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      run_req("reserved", 4'b1011, 64'h0000_0000_5000_0010, 64'h1234, 64'h0);
      check("reserved/const", 64'(last_err), 64'd1);
      run_req("lw_off2", 4'b0010, 64'h0000_0000_6000_0002, 64'h0, 64'h0123_4567_89AB_CDEF);
      check("lw_off2/const", last_data, TRAP ? 64'h0 : 64'hFFFF_FFFF_89AB_CDEF);
      run_req("ld", 4'b1010, 64'h0000_0000_7000_0005, 64'h0, 64'h8877_6655_4433_2211);
      run_req("sw_off4", 4'b0111, 64'h0000_0000_7000_0004, 64'hFFFF_FFFF_CAFE_BABE,
              64'h1111_2222_3333_4444);

      // Randomized cases
      for (int i = 0; i < 24; i++) begin
         run_req("rand", 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom});
      end

      // Reset while a sub-word store is waiting for read data
      @(negedge clock);
      mem_word = 64'hAAAA_BBBB_CCCC_DDDD;
      bus.req_valid = 1'b1; bus.req_op = 4'b0111;
      bus.req_addr = 64'h0000_0000_9000_000C; bus.req_wdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clock);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst/req_ready",  64'(bus.req_ready),  64'd1);
      check("midrst/mem_rd",     64'(bus.mem_rd),     64'd0);
      check("midrst/mem_wr",     64'(bus.mem_wr),     64'd0);
      check("midrst/resp_valid", 64'(bus.resp_valid), 64'd0);
      check("midrst/resp_err",   64'(bus.resp_err),   64'd0);
      check("midrst/resp_data",  bus.resp_data,       64'h0);
      check("midrst/mem_wdata",  bus.mem_wdata,       64'h0);
      check("midrst/mem_addr",   bus.mem_addr,        64'h0);
      @(negedge clock);
      reset = 1'b0;
      rd_n = 0; wr_n = 0; resp_n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (bus.mem_rd) rd_n++;
         if (bus.mem_wr) wr_n++;
         if (bus.resp_valid) resp_n++;
      end
      check("midrst/no_rd",   64'(rd_n),   64'd0);
      check("midrst/no_wr",   64'(wr_n),   64'd0);
      check("midrst/no_resp", 64'(resp_n), 64'd0);
      run_req("after_rst_lbu", 4'b0011, 64'h0000_0000_A000_0007, 64'h0, 64'hF100_0000_0000_0000);
      check("after_rst_lbu/const", last_data, 64'h0000_0000_0000_00F1);
      run_req("after_rst_sh", 4'b1000, 64'h0000_0000_A000_0002, 64'h0000_0000_0000_BEEF,
              64'h1122_3344_5566_7788);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
